// File: rtl/swan_lcd_tx.sv
// WonderSwan Color LCD bus generator: serialises ready/valid pixels onto dclk0/dclk1/blank/video.
// Optional internal test pattern enabled by defining SWAN_LCD_TX_PATTERN_EN.
module swan_lcd_tx #(
   parameter int unsigned H_ACTIVE = 224,
   parameter int unsigned V_ACTIVE = 144,
   parameter int unsigned H_BLANK  = 32,
   parameter int unsigned V_BLANK  = 15,
   parameter int unsigned PXL_DIV  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [11:0] pxlIn,
   input  logic        pxlValid,
   output logic        pxlReady,
   input  logic        clrUnderflow,
`ifdef SWAN_LCD_TX_PATTERN_EN
   input  logic        patSel,
`endif
   output logic        dclk0,
   output logic        dclk1,
   output logic        hblank,
   output logic        vblank,
   output logic [3:0]  video0,
   output logic [3:0]  video1,
   output logic [3:0]  video2,
   output logic        frameStart,
   output logic        underflow,
   output logic        busy
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int unsigned SLOT_W  = (PXL_DIV > 2) ? $clog2(PXL_DIV) : 1;
   localparam int unsigned X_W     = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
   localparam int unsigned Y_W     = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PXL_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_HALF  = SLOT_W'(PXL_DIV / 2);
   localparam logic [X_W-1:0]    X_ACT_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [X_W-1:0]    X_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0]    Y_ACT_LAST = Y_W'(V_ACTIVE - 1);
   localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(V_TOTAL - 1);

   typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [11:0]       vid_q, vid_d;
   logic              fs_q, fs_d;
   logic              und_q, und_d;
   logic              pat_on;
   logic              pat_d;
   logic              slot_end;
   logic              fetch;
   logic              starved;
   logic              strobe;
   logic [11:0]       pix_src;

`ifdef SWAN_LCD_TX_PATTERN_EN
   logic       pat_q;
   logic [7:0] x8;
   logic [7:0] y8;

   assign pat_on = pat_q;
   assign x8     = 8'(x_q);
   assign y8     = 8'(y_q);
   assign pix_src = pat_q ? {x8[7:4], y8[7:4], x8[3:0] ^ y8[3:0]} : pxlIn;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pat_q <= 1'b0;
      else      pat_q <= pat_d;
   end
`else
   assign pat_on  = 1'b0;
   assign pix_src = pxlIn;
`endif

   assign slot_end = (slot_q == SLOT_LAST);
   assign fetch    = (state_q == StActive) && (slot_q == '0);
   assign starved  = fetch && !pat_on && !pxlValid;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_end ? '0 : slot_q + 1'b1;
      x_d     = x_q;
      y_d     = y_q;
      fs_d    = 1'b0;
      pat_d   = pat_on;
      vid_d   = vid_q;
      und_d   = und_q;

      unique case (state_q)
         StIdle: begin
            slot_d = '0;
            x_d    = '0;
            y_d    = '0;
            if (enable) begin
               state_d = StActive;
               fs_d    = 1'b1;
`ifdef SWAN_LCD_TX_PATTERN_EN
               pat_d   = patSel;
`endif
            end
         end
         StActive: begin
            if (slot_end) begin
               x_d = x_q + 1'b1;
               if (x_q == X_ACT_LAST) state_d = StHblank;
            end
         end
         StHblank: begin
            if (slot_end) begin
               if (x_q == X_LAST) begin
                  x_d     = '0;
                  y_d     = y_q + 1'b1;
                  state_d = (y_q < Y_ACT_LAST) ? StActive : StVblank;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         StVblank: begin
            if (slot_end) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     // Frame boundary: the only point besides IDLE where enable is honoured.
                     y_d = '0;
                     if (enable) begin
                        state_d = StActive;
                        fs_d    = 1'b1;
`ifdef SWAN_LCD_TX_PATTERN_EN
                        pat_d   = patSel;
`endif
                     end else begin
                        state_d = StIdle;
                     end
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (fetch) vid_d = (pat_on || pxlValid) ? pix_src : 12'h000;
      if (state_d == StVblank || state_d == StIdle) vid_d = 12'h000;

      // Set wins over clear so a starvation in the clearing cycle is not lost.
      if (clrUnderflow) und_d = 1'b0;
      if (starved)      und_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         slot_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         vid_q   <= 12'h000;
         fs_q    <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vid_q   <= vid_d;
         fs_q    <= fs_d;
         und_q   <= und_d;
      end
   end

   assign strobe     = (state_q == StActive) && (slot_q >= SLOT_HALF);
   assign dclk0      = strobe && !x_q[0];
   assign dclk1      = strobe && x_q[0];
   assign hblank     = (state_q != StActive);
   assign vblank     = (state_q == StVblank) || (state_q == StIdle);
   assign pxlReady   = fetch && !pat_on;
   assign video0     = vid_q[11:8];
   assign video1     = vid_q[7:4];
   assign video2     = vid_q[3:0];
   assign frameStart = fs_q;
   assign underflow  = und_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: doc/swan_lcd_tx.md
Name: swan_lcd_tx

Overview:
- Emulates the WonderSwan Color LCD output bus: dclk0, dclk1, hblank, vblank and three 4-bit colour nibbles.
- Serialises 12-bit pixels from a ready/valid source into the same pin-level timing that the capture path consumes.
- Used as loopback stimulus for the capture/HDMI pipeline, and for bring-up without a console attached.
- Sits in the pxlClk domain, between a pixel source (BRAM reader or pattern) and the FPGA pins or capture inputs.

Parameters:
- H_ACTIVE, 224, active pixels per line.
- V_ACTIVE, 144, active lines per frame.
- H_BLANK, 32, blank pixel slots per line.
- V_BLANK, 15, blank lines per frame.
- PXL_DIV, 8, clk cycles per pixel slot; must be even and >=4.

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  run request; sampled only at frame boundaries.
- pxlIn  in  12  pixel {R[11:8],G[7:4],B[3:0]}.
- pxlValid  in  1  pxlIn valid.
- pxlReady  out  1  pixel consumed this cycle.
- clrUnderflow  in  1  clears underflow.
- dclk0  out  1  even-pixel strobe.
- dclk1  out  1  odd-pixel strobe.
- hblank  out  1  horizontal blank.
- vblank  out  1  vertical blank.
- video0/video1/video2  out  4 each  R/G/B nibble.
- frameStart  out  1  one-cycle pulse.
- underflow  out  1  sticky starvation flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0 except hblank=1 and vblank=1.
  - Counters slot/x/y reset to 0.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - Outputs held as at reset.
  - enable=1 -> ACTIVE with x=0, y=0, slot=0.
  - frameStart pulses on the transition cycle.
- Slot counter: 0..PXL_DIV-1, wraps. One slot = one pixel position.
- ACTIVE, pixel fetch:
  - pxlReady = (state==ACTIVE && slot==0), combinational.
  - If pxlValid is also 1: pixel is consumed; video0/1/2 register it and update in the cycle after slot 0.
  - If pxlValid=0 at slot 0: video=0 for that slot; underflow<=1; the pixel position still advances. No stall, because bus timing is fixed.
- ACTIVE, strobes:
  - Strobes are high when slot >= PXL_DIV/2.
  - dclk0 strobes when x is even; dclk1 strobes when x is odd.
  - The inactive strobe stays 0.
  - hblank=0 and vblank=0.
- ACTIVE -> HBLANK at end of slot for x=H_ACTIVE-1.
- HBLANK:
  - Lasts H_BLANK slots; hblank=1, strobes 0, video holds the last value.
  - At its end: y<V_ACTIVE-1 -> ACTIVE with y+1, x=0; otherwise -> VBLANK with vblank=1.
- VBLANK:
  - V_BLANK lines, each (H_ACTIVE+H_BLANK)*PXL_DIV cycles.
  - hblank=1 and vblank=1 throughout; strobes 0; video=0.
  - At end: enable=1 -> ACTIVE (y=0, x=0), frameStart pulses on the first cycle; enable=0 -> IDLE.
- enable deassertion mid-frame: the current frame completes, including VBLANK, before entering IDLE. There are no truncated frames.
- underflow:
  - Set-dominant: a starved fetch and clrUnderflow in the same cycle leaves it at 1.
  - Cleared only by clrUnderflow or reset.
- Reset mid-frame: all outputs take reset values asynchronously; no partial line is resumed.
- Widths: x and y are $clog2 of the larger of their respective total counts; no wrap occurs inside a frame.

Optional Feature:
- Macro: SWAN_LCD_TX_PATTERN_EN.
- When defined:
  - Adds input port patSel (1 bit).
  - patSel=1 selects internal pixel = {x[7:4], y[7:4], x[3:0]^y[3:0]}.
  - With patSel=1: pxlReady is held 0 and underflow never sets.
  - patSel is sampled only at frame start.
- When undefined: no patSel port; only the external source is used. Logic is otherwise identical.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, PXL_DIV=4, so one line = 24 cycles and one frame = 96 cycles.
1. Reset, then enable=1 with pxlValid tied 1 and pxlIn incrementing from 12'h000 -> frameStart at cycle 0; four pxlReady pulses per line spaced 4 cycles apart; video0/1/2 for pixel 1 = 0/0/1.
2. Strobe check -> dclk0 high at cycles 2-3 and 10-11; dclk1 high at 6-7 and 14-15; hblank high at cycles 16-23; vblank high at cycles 72-95; second frameStart at cycle 96.
3. pxlValid=0 at the third pixel slot of line 0 -> video=0 for that slot; underflow=1 and stays 1. clrUnderflow plus a starved fetch in the same cycle -> underflow remains 1.
4. enable dropped at cycle 30 -> frame completes; busy falls at cycle 96; IDLE outputs hblank=1, vblank=1, strobes 0.
5. rst asserted at cycle 40 -> outputs return to reset values immediately. Release with enable=1 -> new frame starts with x=0, y=0 and frameStart.
6. With SWAN_LCD_TX_PATTERN_EN, patSel=1 -> pixel x=3, y=2 drives video 0/0/1; pxlReady stays 0.
